// File: rtl/cdc_handshake_dmux_pkg.sv
// Shared state encodings and synchronizer depth rules for the req/ack CDC data mux.
package cdc_handshake_dmux_pkg;

  typedef enum logic [0:0] {
    SIdle,
    SBusy
  } src_state_e;

  typedef enum logic [0:0] {
    DWait,
    DHold
  } dst_state_e;

  localparam int unsigned MinSyncStages = 2;

  // A chain shorter than two flops gives no metastability settling time, so clamp up.
  function automatic int unsigned sync_stages(input int unsigned requested);
    return (requested < MinSyncStages) ? MinSyncStages : requested;
  endfunction

endpackage

// File: rtl/cdc_handshake_dmux_sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset to 0.
module cdc_handshake_dmux_sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/cdc_handshake_dmux.sv
// Toggle req/ack clock-domain crossing for one data word at a time, valid/ready on both sides.
module cdc_handshake_dmux
  import cdc_handshake_dmux_pkg::*;
#(
  parameter int unsigned P_SYNC_STAGE = 2,
  parameter int unsigned P_DATA_WIDTH = 16
) (
  input  logic                    i_clk_src,
  input  logic                    i_rstn_src,
  input  logic                    i_clk_dst,
  input  logic                    i_rstn_dst,
  input  logic                    i_valid_src,
  input  logic [P_DATA_WIDTH-1:0] i_data_src,
  output logic                    o_ready_src,
  output logic                    o_valid_dst,
  output logic [P_DATA_WIDTH-1:0] o_data_dst,
  input  logic                    i_ready_dst
);

  localparam int unsigned SyncStages = sync_stages(P_SYNC_STAGE);

  // Source domain
  src_state_e              src_state_q, src_state_d;
  logic [P_DATA_WIDTH-1:0] hold_q, hold_d;
  logic                    req_tgl_q, req_tgl_d;
  logic                    ack_seen_q, ack_seen_d;
  logic                    ack_sync;
  logic                    accept;

  // Destination domain
  dst_state_e              dst_state_q, dst_state_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic                    req_seen_q, req_seen_d;
  logic                    ack_tgl_q, ack_tgl_d;
  logic                    req_sync;
  logic                    take;

  cdc_handshake_dmux_sync_bit #(
    .Stages (SyncStages)
  ) u_sync_req (
    .clk_i  (i_clk_dst),
    .rst_ni (i_rstn_dst),
    .d_i    (req_tgl_q),
    .q_o    (req_sync)
  );

  cdc_handshake_dmux_sync_bit #(
    .Stages (SyncStages)
  ) u_sync_ack (
    .clk_i  (i_clk_src),
    .rst_ni (i_rstn_src),
    .d_i    (ack_tgl_q),
    .q_o    (ack_sync)
  );

  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      src_state_q <= SIdle;
      hold_q      <= '0;
      req_tgl_q   <= 1'b0;
      ack_seen_q  <= 1'b0;
    end else begin
      src_state_q <= src_state_d;
      hold_q      <= hold_d;
      req_tgl_q   <= req_tgl_d;
      ack_seen_q  <= ack_seen_d;
    end
  end

  // hold_q is only written on accept, so it is stable for the whole round trip
  // and the destination may sample it directly without a synchronizer.
  always_comb begin
    src_state_d = src_state_q;
    hold_d      = hold_q;
    req_tgl_d   = req_tgl_q;
    ack_seen_d  = ack_seen_q;
    unique case (src_state_q)
      SIdle: begin
        if (accept) begin
          src_state_d = SBusy;
          hold_d      = i_data_src;
          req_tgl_d   = ~req_tgl_q;
        end
      end
      SBusy: begin
        if (ack_sync != ack_seen_q) begin
          src_state_d = SIdle;
          ack_seen_d  = ack_sync;
        end
      end
    endcase
  end

  always_comb begin
    o_ready_src = (src_state_q == SIdle);
    accept      = i_valid_src & o_ready_src;
  end

  always_ff @(posedge i_clk_dst or negedge i_rstn_dst) begin
    if (!i_rstn_dst) begin
      dst_state_q <= DWait;
      data_q      <= '0;
      req_seen_q  <= 1'b0;
      ack_tgl_q   <= 1'b0;
    end else begin
      dst_state_q <= dst_state_d;
      data_q      <= data_d;
      req_seen_q  <= req_seen_d;
      ack_tgl_q   <= ack_tgl_d;
    end
  end

  // Request edges are only looked at in DWait; one word is ever in flight.
  always_comb begin
    dst_state_d = dst_state_q;
    data_d      = data_q;
    req_seen_d  = req_seen_q;
    ack_tgl_d   = ack_tgl_q;
    unique case (dst_state_q)
      DWait: begin
        if (req_sync != req_seen_q) begin
          dst_state_d = DHold;
          data_d      = hold_q;
          req_seen_d  = req_sync;
        end
      end
      DHold: begin
        if (take) begin
          dst_state_d = DWait;
          ack_tgl_d   = ~ack_tgl_q;
        end
      end
    endcase
  end

  always_comb begin
    o_valid_dst = (dst_state_q == DHold);
    o_data_dst  = data_q;
    take        = o_valid_dst & i_ready_dst;
  end

endmodule
